// File: rtl/instr_loader_if.sv
// instr_loader_if: byte-stream handshake, instruction-memory write port and CPU control of the boot loader.
interface instr_loader_if #(parameter int ADDR_W = 32);
  logic start, in_valid, in_ready, mem_we, cpu_hold, done, err;
  logic [7:0] in_byte;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_data;
  modport master (input start, in_valid, in_byte, output in_ready, mem_we, mem_addr, mem_data, cpu_hold, done, err);
  modport slave (output start, in_valid, in_byte, input in_ready, mem_we, mem_addr, mem_data, cpu_hold, done, err);
endinterface

// File: rtl/instr_loader.sv
// instr_loader: assembles a big-endian byte stream into instruction-memory words and freezes the CPU until loaded.
// Macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte that must match before the CPU is released.
module instr_loader #(
  parameter int DEPTH = 256,
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic rst,
  instr_loader_if.master bus
);
`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE} state_t;
  localparam state_t POST = CHK;
`else
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, DONE} state_t;
  localparam state_t POST = DONE;
`endif
  state_t state_q, state_d;
  logic [7:0] n_hi;
  logic [15:0] n, idx, len;
  logic [1:0] bcnt;
  logic [23:0] acc;
  logic hs, last, fail, enter_len;
  assign bus.in_ready = state_q != IDLE && state_q != DONE;
  assign hs = bus.in_valid & bus.in_ready;
  assign len = {n_hi, bus.in_byte};
  assign last = bcnt == 2'd3 && idx + 16'd1 == n;
  assign enter_len = state_d == LEN_HI && state_q != LEN_HI;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] chk;
  assign fail = state_q == CHK ? chk != bus.in_byte : state_q == LEN_LO && len > 16'(DEPTH);
  always_ff @(posedge clk)
    if (rst || enter_len) chk <= '0;
    else if (hs && state_q == DATA) chk <= chk ^ bus.in_byte;
`else
  assign fail = state_q == LEN_LO && len > 16'(DEPTH);
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = bus.start ? LEN_HI : state_q;
      LEN_HI: state_d = hs ? LEN_LO : state_q;
      LEN_LO: state_d = !hs ? state_q : len == 16'd0 ? POST : len > 16'(DEPTH) ? DONE : DATA;
      DATA: state_d = hs && last ? POST : state_q;
`ifdef LOADER_CHECKSUM_EN
      CHK: state_d = hs ? DONE : state_q;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_hi <= '0;
      n <= '0;
      idx <= '0;
      bcnt <= '0;
      acc <= '0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_data <= '0;
      bus.cpu_hold <= 1'b1;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      state_q <= state_d;
      bus.mem_we <= 1'b0;
      if (enter_len) begin
        idx <= '0;
        bcnt <= '0;
        bus.cpu_hold <= 1'b1;
        bus.done <= 1'b0;
        bus.err <= 1'b0;
      end
      // a failed load keeps the CPU frozen
      if (state_d == DONE && state_q != DONE) begin
        bus.done <= 1'b1;
        bus.err <= fail;
        bus.cpu_hold <= fail;
      end
      if (hs && state_q == LEN_HI) n_hi <= bus.in_byte;
      if (hs && state_q == LEN_LO) n <= len;
      if (hs && state_q == DATA) begin
        acc <= {acc[15:0], bus.in_byte};
        bcnt <= bcnt + 2'd1;
        if (bcnt == 2'd3) begin
          bus.mem_we <= 1'b1;
          bus.mem_data <= {acc, bus.in_byte};
          bus.mem_addr <= ADDR_W'({idx, 2'b00});
          idx <= idx + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed tests of the instruction loader (stream, stalls, oversize, reset, empty, checksum).
module tb_instr_loader;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  instr_loader_if #(.ADDR_W(32)) bus();
  instr_loader #(.DEPTH(256), .ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0, fails = 0;
  typedef struct {logic [31:0] addr; logic [31:0] data; logic done;} wr_t;
  wr_t wq[$];
  always @(posedge clk) begin
    #1;
    if (bus.mem_we === 1'b1) wq.push_back('{bus.mem_addr, bus.mem_data, bus.done});
  end
  always @(negedge clk) if (!rst) begin
    tests++;
    if (bus.in_ready === 1'b1 && bus.done === 1'b1) begin
      fails++;
      $display("FAIL ready_in_done: in_ready=%b done=%b, expected in_ready=0", bus.in_ready, bus.done);
    end
  end
  task automatic do_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wq.delete();
  endtask
  task automatic pulse_start;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input bit gap);
    int k = 0;
    if (gap) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_byte = b;
    while (bus.in_ready !== 1'b1 && k < 8) begin
      @(negedge clk);
      k++;
    end
    if (bus.in_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: byte %h in_ready=%b, expected 1", b, bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  task automatic send_stream(input logic [7:0] s[$], input bit rnd);
    logic [7:0] x = 8'h00;
    foreach (s[i]) begin
      send(s[i], rnd ? 1'($urandom_range(0, 1)) : 1'b0);
      if (i > 1) x ^= s[i];
    end
    if (CHK) send(x, 1'b0);
  endtask
  task automatic test_reset;
    do_reset;
    tests += 7;
    if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b, expected 0", bus.in_ready); end
    if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we: got %b, expected 0", bus.mem_we); end
    if (bus.mem_addr !== 32'h0) begin fails++; $display("FAIL reset_mem_addr: got %h, expected 0", bus.mem_addr); end
    if (bus.mem_data !== 32'h0) begin fails++; $display("FAIL reset_mem_data: got %h, expected 0", bus.mem_data); end
    if (bus.cpu_hold !== 1'b1) begin fails++; $display("FAIL reset_cpu_hold: got %b, expected 1", bus.cpu_hold); end
    if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b, expected 0", bus.done); end
    if (bus.err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b, expected 0", bus.err); end
  endtask
  task automatic check_two_words(input string tag);
    tests += 4;
    if (bus.done !== 1'b1) begin fails++; $display("FAIL %s_done: got %b, expected 1", tag, bus.done); end
    if (bus.cpu_hold !== 1'b0) begin fails++; $display("FAIL %s_cpu_hold: got %b, expected 0", tag, bus.cpu_hold); end
    if (bus.err !== 1'b0) begin fails++; $display("FAIL %s_err: got %b, expected 0", tag, bus.err); end
    if (wq.size() != 2) begin
      fails++;
      $display("FAIL %s_write_count: got %0d, expected 2", tag, wq.size());
    end else begin
      tests += 5;
      if (wq[0].addr !== 32'h0) begin fails++; $display("FAIL %s_addr0: got %h, expected 0", tag, wq[0].addr); end
      if (wq[0].data !== 32'h12345678) begin fails++; $display("FAIL %s_data0: got %h, expected 12345678", tag, wq[0].data); end
      if (wq[1].addr !== 32'h4) begin fails++; $display("FAIL %s_addr1: got %h, expected 4", tag, wq[1].addr); end
      if (wq[1].data !== 32'h9abcdef0) begin fails++; $display("FAIL %s_data1: got %h, expected 9abcdef0", tag, wq[1].data); end
      if (wq[1].done !== !CHK) begin fails++; $display("FAIL %s_done_with_last_write: got %b, expected %b", tag, wq[1].done, !CHK); end
    end
  endtask
  task automatic test_basic;
    do_reset;
    pulse_start;
    tests += 2;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL basic_ready_after_start: got %b, expected 1", bus.in_ready); end
    if (bus.cpu_hold !== 1'b1) begin fails++; $display("FAIL basic_hold_during_load: got %b, expected 1", bus.cpu_hold); end
    send_stream('{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9a, 8'hbc, 8'hde, 8'hf0}, 1'b0);
    tests++;
    if (bus.mem_we !== !CHK) begin fails++; $display("FAIL basic_final_we: got %b, expected %b", bus.mem_we, !CHK); end
    check_two_words("basic");
    @(negedge clk);
    tests += 4;
    if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL basic_we_drop: got %b, expected 0", bus.mem_we); end
    if (bus.mem_addr !== 32'h4) begin fails++; $display("FAIL basic_addr_hold: got %h, expected 4", bus.mem_addr); end
    if (bus.mem_data !== 32'h9abcdef0) begin fails++; $display("FAIL basic_data_hold: got %h, expected 9abcdef0", bus.mem_data); end
    if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL basic_ready_in_done: got %b, expected 0", bus.in_ready); end
  endtask
  task automatic test_stall;
    do_reset;
    tests++;
    if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL stall_ready_idle: got %b, expected 0", bus.in_ready); end
    pulse_start;
    send_stream('{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9a, 8'hbc, 8'hde, 8'hf0}, 1'b1);
    repeat (2) @(negedge clk);
    check_two_words("stall");
  endtask
  task automatic test_oversize;
    do_reset;
    pulse_start;
    send(8'h01, 1'b0);
    send(8'h01, 1'b0);
    tests += 6;
    if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL over_we: got %b, expected 0", bus.mem_we); end
    if (bus.done !== 1'b1) begin fails++; $display("FAIL over_done: got %b, expected 1", bus.done); end
    if (bus.err !== 1'b1) begin fails++; $display("FAIL over_err: got %b, expected 1", bus.err); end
    if (bus.cpu_hold !== 1'b1) begin fails++; $display("FAIL over_cpu_hold: got %b, expected 1", bus.cpu_hold); end
    if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL over_ready: got %b, expected 0", bus.in_ready); end
    if (wq.size() != 0) begin fails++; $display("FAIL over_writes: got %0d, expected 0", wq.size()); end
    repeat (3) @(negedge clk);
    pulse_start;
    tests += 3;
    if (bus.err !== 1'b0) begin fails++; $display("FAIL over_restart_err: got %b, expected 0", bus.err); end
    if (bus.done !== 1'b0) begin fails++; $display("FAIL over_restart_done: got %b, expected 0", bus.done); end
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL over_restart_ready: got %b, expected 1", bus.in_ready); end
  endtask
  task automatic test_mid_reset;
    do_reset;
    pulse_start;
    send(8'h00, 1'b0);
    send(8'h01, 1'b0);
    send(8'haa, 1'b0);
    send(8'hbb, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests += 5;
    if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL midrst_we: got %b, expected 0", bus.mem_we); end
    if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL midrst_ready: got %b, expected 0", bus.in_ready); end
    if (bus.cpu_hold !== 1'b1) begin fails++; $display("FAIL midrst_cpu_hold: got %b, expected 1", bus.cpu_hold); end
    if (bus.done !== 1'b0) begin fails++; $display("FAIL midrst_done: got %b, expected 0", bus.done); end
    if (wq.size() != 0) begin fails++; $display("FAIL midrst_writes: got %0d, expected 0", wq.size()); end
    pulse_start;
    send_stream('{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44}, 1'b0);
    tests += 2;
    if (bus.cpu_hold !== 1'b0) begin fails++; $display("FAIL reload_cpu_hold: got %b, expected 0", bus.cpu_hold); end
    if (wq.size() != 1) begin
      fails++;
      $display("FAIL reload_write_count: got %0d, expected 1", wq.size());
    end else begin
      tests += 2;
      if (wq[0].addr !== 32'h0) begin fails++; $display("FAIL reload_addr: got %h, expected 0", wq[0].addr); end
      if (wq[0].data !== 32'h11223344) begin fails++; $display("FAIL reload_data: got %h, expected 11223344", wq[0].data); end
    end
  endtask
  task automatic test_zero;
    do_reset;
    pulse_start;
    send_stream('{8'h00, 8'h00}, 1'b0);
    tests += 5;
    if (bus.done !== 1'b1) begin fails++; $display("FAIL zero_done: got %b, expected 1", bus.done); end
    if (bus.err !== 1'b0) begin fails++; $display("FAIL zero_err: got %b, expected 0", bus.err); end
    if (bus.cpu_hold !== 1'b0) begin fails++; $display("FAIL zero_cpu_hold: got %b, expected 0", bus.cpu_hold); end
    if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL zero_we: got %b, expected 0", bus.mem_we); end
    if (wq.size() != 0) begin fails++; $display("FAIL zero_writes: got %0d, expected 0", wq.size()); end
  endtask
`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum;
    logic [7:0] s[$] = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h04, 8'h08};
    do_reset;
    pulse_start;
    foreach (s[i]) send(s[i], 1'b0);
    send(8'h0f, 1'b0);
    tests += 2;
    if (bus.err !== 1'b0) begin fails++; $display("FAIL chk_good_err: got %b, expected 0", bus.err); end
    if (bus.cpu_hold !== 1'b0) begin fails++; $display("FAIL chk_good_hold: got %b, expected 0", bus.cpu_hold); end
    wq.delete();
    pulse_start;
    foreach (s[i]) send(s[i], 1'b0);
    send(8'h0e, 1'b0);
    tests += 4;
    if (bus.err !== 1'b1) begin fails++; $display("FAIL chk_bad_err: got %b, expected 1", bus.err); end
    if (bus.cpu_hold !== 1'b1) begin fails++; $display("FAIL chk_bad_hold: got %b, expected 1", bus.cpu_hold); end
    if (wq.size() != 1) begin fails++; $display("FAIL chk_bad_writes: got %0d, expected 1", wq.size()); end
    else if (wq[0].data !== 32'h01020408) begin fails++; $display("FAIL chk_bad_data: got %h, expected 01020408", wq[0].data); end
  endtask
`endif
  initial begin
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte = 8'h00;
    test_reset;
    test_basic;
    test_stall;
    test_oversize;
    test_mid_reset;
    test_zero;
`ifdef LOADER_CHECKSUM_EN
    test_checksum;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
